fifo_decimation_4_write_ctrl: RTL

- Write-side sequencer for the 32-bit decimation FIFO: accepts a full-rate sample stream, keeps every DECIM-th sample, and writes it into the FIFO's Avalon-MM write slave.
- Honours the slave's waitrequest, which is FIFO full with 3 words of headroom.
- Provides start/stop control, a one-entry holding register, a selectable drop-or-stall policy, and status counters.
- Sits in the wrclock domain, between the sample source and the FIFO write slave.

---
 rtl/fifo_decimation_4_pkg.sv | 24 ++
 rtl/fifo_decimation_4_phase_counter.sv | 34 +++
 rtl/fifo_decimation_4_write_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/fifo_decimation_4_pkg.sv
// Shared types and helpers for the decimation FIFO write-side sequencer.
package fifo_decimation_4_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_decimation_4_phase_counter.sv
// Modulo-DECIM accept counter; flags the sample index that is kept.
module fifo_decimation_4_phase_counter
    import fifo_decimation_4_pkg::*;
#(
    parameter int DECIM = 4,
    parameter int PHASE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic advance,
    output logic kept
);

    localparam int PW = clog2(DECIM);

    logic [PW-1:0] phase;

    // clear wins so a sample accepted on the way to IDLE cannot leak a phase
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            phase <= '0;
        end else if (advance) begin
            if (phase == PW'(DECIM - 1)) begin
                phase <= '0;
            end else begin
                phase <= phase + PW'(1);
            end
        end
    end

    assign kept = (phase == PW'(PHASE));

endmodule

// File: rtl/fifo_decimation_4_write_ctrl.sv
// Decimating write sequencer in front of the FIFO's Avalon-MM write slave.
module fifo_decimation_4_write_ctrl
    import fifo_decimation_4_pkg::*;
#(
    parameter int DECIM        = 4,
    parameter int PHASE        = 0,
    parameter int DROP_ON_FULL = 0,
    parameter int CNT_W        = 16
) (
    input  logic              wrclock,
    input  logic              wrreset,
    input  logic              enable,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic [CNT_W-1:0]  written_count,
    output logic [CNT_W-1:0]  drop_count
);

    state_t            state;
    state_t            state_nxt;
    logic              pending;
    logic              pending_nxt;
    logic [DATA_W-1:0] hold;
    logic              kept;
    logic              accept;
    logic              blocked;
    logic              stall;
    logic              load;
    logic              drop;
    logic              wr_done;
    logic              phase_clr;

    fifo_decimation_4_phase_counter #(
        .DECIM (DECIM),
        .PHASE (PHASE)
    ) u_phase (
        .clk     (wrclock),
        .rst     (wrreset),
        .clear   (phase_clr),
        .advance (accept),
        .kept    (kept)
    );

    assign wr_done = pending & ~avm_waitrequest;
    assign blocked = pending & avm_waitrequest;
    assign stall   = (DROP_ON_FULL == 0) && kept && blocked;

    assign in_ready = (state == RUN) && !stall;
    assign accept   = in_valid & in_ready;
    assign load     = accept & kept & ~blocked;
    assign drop     = accept & kept & blocked;

    assign pending_nxt = load | (pending & ~wr_done);

    // leave RUN via DRAIN whenever a word will still be outstanding
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (enable) state_nxt = RUN;
            end
            RUN: begin
                if (!enable) state_nxt = pending_nxt ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (!pending_nxt) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign phase_clr = (state_nxt == IDLE);

    always_ff @(posedge wrclock) begin
        if (wrreset) begin
            state         <= IDLE;
            pending       <= 1'b0;
            hold          <= '0;
            written_count <= '0;
            drop_count    <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (load) hold <= in_data;
            if (wr_done && !(&written_count)) begin
                written_count <= written_count + CNT_W'(1);
            end
            if ((DROP_ON_FULL != 0) && drop && !(&drop_count)) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

    assign avm_write     = pending;
    assign avm_writedata = hold;
    assign busy          = (state != IDLE);

endmodule
